intersection_phase_ctrl: RTL and testbench
==========================================

Name: intersection_phase_ctrl

Overview:
- Two-approach intersection phase scheduler (north-south, east-west) driving per-approach 4-bit RGB lamp channels.
- Sequences the light phases and arbitrates pedestrian crossing requests against the running vehicle green.
- Supports auto (timed) and manual (button-stepped) operation.
- Sits between the board inputs (mode switch, debounced buttons) and the RGB LED pins, in place of the single-approach light FSM.

Parameters:
- TICKS_PER_SEC, 10, clk cycles per timing second (10 for simulation, 50_000_000 on board).
- GREEN_SEC, 5, nominal green duration in seconds.
- MIN_GREEN_SEC, 2, minimum green before a pedestrian request may truncate it.
- YELLOW_SEC, 2, yellow duration in seconds.
- ALLRED_SEC, 1, all-red clearance duration in seconds.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- mode  in  1  0 = auto, 1 = manual
- btn  in  1  manual advance; level input, synchronous rising-edge detected internally
- ped_req_ns  in  1  request to cross the NS road; level or pulse
- ped_req_ew  in  1  request to cross the EW road; level or pulse
- ns_r, ns_g, ns_b  out  4 each  NS lamp colour
- ew_r, ew_g, ew_b  out  4 each  EW lamp colour
- walk_ns  out  1  walk indication for crossing the NS road
- walk_ew  out  1  walk indication for crossing the EW road
- phase  out  3  current state code, for debug

Behaviour:
- State cycle: AR_A(0) -> NS_G(1) -> NS_Y(2) -> AR_B(3) -> EW_G(4) -> EW_Y(5) -> AR_A.
- Reset:
  - state = AR_A; both approaches red; walks 0.
  - Pending flags, second counter, prescaler and btn edge register all 0.
- Colour decode (Moore, from the state register):
  - red = r F, g 0, b 0.
  - green = r 0, g F, b 0.
  - yellow = r F, g F, b 0.
  - The non-moving approach is always red.
  - Outputs change on the same clock edge that updates the state.
- Timing:
  - The prescaler emits tick every TICKS_PER_SEC cycles.
  - sec_cnt increments on tick.
  - Prescaler and sec_cnt clear on every state entry.
  - Auto exit occurs when tick fires and sec_cnt == DUR-1, so a phase lasts exactly DUR*TICKS_PER_SEC cycles.
- Pedestrian arbitration:
  - ped_req_ns sets pend_ns; ped_req_ew sets pend_ew. Both are sticky.
  - Walk across the NS road is granted in EW_G; walk across the EW road is granted in NS_G.
  - On entry to NS_G: if pend_ew, walk_ew = 1 for the whole of NS_G and pend_ew clears in the entry cycle. The EW_G/pend_ns case is symmetric.
  - A request arriving during its own granted green stays pending for the next grant.
  - Truncation: during NS_G, if pend_ns = 1, exit at the first tick where sec_cnt >= MIN_GREEN_SEC-1; otherwise exit at GREEN_SEC. EW_G is symmetric with pend_ew.
  - Walk deasserts on green exit. There is no walk during yellow or all-red.
- Simultaneous events:
  - A request on the clearing cycle of its own pending flag keeps the flag set.
  - Both requests together are each handled at their respective next green.
- Manual mode:
  - Timers are held at 0 and tick is ignored.
  - Each btn rising edge advances one state.
  - Green entry and walk rules are the same as in auto.
  - Holding btn high advances once.
  - btn edges in auto mode are ignored, but the edge register still tracks btn.
- Mode changes:
  - auto -> manual: state is held and timers clear.
  - manual -> auto: the current state restarts its full duration from 0.
- Reset asserted mid-phase returns to AR_A immediately (asynchronous). Pending requests are lost.

Decomposition:
- Shared package/include holds:
  - state codes: AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y;
  - colour constants: COL_RED, COL_GRN, COL_YEL, COL_OFF as 12-bit {r,g,b};
  - the phase width.
- One sub-module: tick_prescaler.
  - Inputs: clk, rst, clr, en. Output: tick.
  - Parameter: TICKS_PER_SEC.

Test Plan:
- Auto, no requests, default parameters, reset released at t0:
  - AR_A for 10 cycles, then NS_G 50 (ns_g = F, ew_r = F), NS_Y 20 (ns_r = F, ns_g = F), AR_B 10, EW_G 50, EW_Y 20, back to AR_A.
  - Walks stay 0 throughout.
- ped_req_ew pulsed during AR_A:
  - walk_ew = 1 for exactly the 50 cycles of NS_G, and pend_ew = 0 after NS_G entry.
- ped_req_ns pulsed 5 cycles into NS_G: NS_G ends at cycle 20 (MIN_GREEN). Then NS_Y, AR_B, and EW_G with walk_ns = 1.
- ped_req_ns pulsed at cycle 35 of NS_G: NS_G exits at the next tick (cycle 40).
- Manual mode:
  - Three btn pulses (1 cycle each) move AR_A -> NS_G -> NS_Y -> AR_B, with phase reading 1, 2, 3.
  - btn held high for 30 cycles gives exactly one advance.
  - No timed exits occur while mode = 1.
- rst asserted mid-EW_G for 5 cycles with pend_ns set:
  - Outputs go all red asynchronously, with walks 0.
  - After release: AR_A for 10 cycles, then NS_G with walk_ew = 0.

Source files
------------

// File: rtl/intersection_phase_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intersection_phase_ctrl_pkg                                          |
// | Phase codes, lamp colour words and phase sequencing helper.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package intersection_phase_ctrl_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    AR_A = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR_B = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5
  } phase_e;

  // Lamp colour words packed as {r, g, b}, 4 bits per channel.
  localparam logic [11:0] COL_RED = 12'hF00;
  localparam logic [11:0] COL_GRN = 12'h0F0;
  localparam logic [11:0] COL_YEL = 12'hFF0;
  localparam logic [11:0] COL_OFF = 12'h000;

  function automatic phase_e next_phase(input phase_e cur);
    phase_e nxt;
    nxt = AR_A;
    case (cur)
      AR_A:    nxt = NS_G;
      NS_G:    nxt = NS_Y;
      NS_Y:    nxt = AR_B;
      AR_B:    nxt = EW_G;
      EW_G:    nxt = EW_Y;
      EW_Y:    nxt = AR_A;
      default: nxt = AR_A;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intersection_phase_ctrl_tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_prescaler                                                       |
// | One-cycle tick every TICKS_PER_SEC enabled cycles; clr restarts it.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tick_prescaler #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int c_w = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [c_w-1:0] c_last = c_w'(TICKS_PER_SEC - 1);

  logic [c_w-1:0] cnt_q;
  logic [c_w-1:0] cnt_d;

  assign tick = en & (cnt_q == c_last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/intersection_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intersection_phase_ctrl                                              |
// | Two-approach phase scheduler with pedestrian walk arbitration.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module intersection_phase_ctrl
  import intersection_phase_ctrl_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10,
  parameter int GREEN_SEC     = 5,
  parameter int MIN_GREEN_SEC = 2,
  parameter int YELLOW_SEC    = 2,
  parameter int ALLRED_SEC    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic               btn,
  input  logic               ped_req_ns,
  input  logic               ped_req_ew,
  output logic [3:0]         ns_r,
  output logic [3:0]         ns_g,
  output logic [3:0]         ns_b,
  output logic [3:0]         ew_r,
  output logic [3:0]         ew_g,
  output logic [3:0]         ew_b,
  output logic               walk_ns,
  output logic               walk_ew,
  output logic [PHASE_W-1:0] phase
);

  localparam logic [7:0] c_green_last  = 8'(GREEN_SEC - 1);
  localparam logic [7:0] c_min_last    = 8'(MIN_GREEN_SEC - 1);
  localparam logic [7:0] c_yellow_last = 8'(YELLOW_SEC - 1);
  localparam logic [7:0] c_allred_last = 8'(ALLRED_SEC - 1);

  phase_e     state_q, state_d;
  logic [7:0] sec_q, sec_d;
  logic       pend_ns_q, pend_ns_d;
  logic       pend_ew_q, pend_ew_d;
  logic       walk_ns_q, walk_ns_d;
  logic       walk_ew_q, walk_ew_d;
  logic       btn_q;

  logic       w_tick;
  logic       w_btn_rise;
  logic       w_timed_exit;
  logic       w_advance;
  logic       w_changing;
  logic       w_enter_nsg;
  logic       w_enter_ewg;
  logic       w_tmr_clr;
  logic [11:0] w_ns_rgb;
  logic [11:0] w_ew_rgb;

  assign w_btn_rise = btn & ~btn_q;
  // Timers restart on every phase entry and are frozen at zero in manual mode.
  assign w_tmr_clr  = mode | w_changing;

  tick_prescaler #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_tick_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (w_tmr_clr),
    .en  (~mode),
    .tick(w_tick)
  );

  always_comb begin
    w_timed_exit = 1'b0;
    case (state_q)
      AR_A, AR_B: w_timed_exit = (sec_q >= c_allred_last);
      NS_Y, EW_Y: w_timed_exit = (sec_q >= c_yellow_last);
      // A waiting pedestrian cuts the conflicting green short after the minimum.
      NS_G:       w_timed_exit = (sec_q >= c_green_last) | (pend_ns_q & (sec_q >= c_min_last));
      EW_G:       w_timed_exit = (sec_q >= c_green_last) | (pend_ew_q & (sec_q >= c_min_last));
      default:    w_timed_exit = 1'b1;
    endcase

    w_advance = mode ? w_btn_rise : (w_tick & w_timed_exit);

    state_d = state_q;
    if (w_advance) begin
      state_d = next_phase(state_q);
    end

    w_changing  = (state_d != state_q);
    w_enter_nsg = w_changing & (state_d == NS_G);
    w_enter_ewg = w_changing & (state_d == EW_G);

    pend_ew_d = ped_req_ew | (pend_ew_q & ~w_enter_nsg);
    pend_ns_d = ped_req_ns | (pend_ns_q & ~w_enter_ewg);

    walk_ew_d = 1'b0;
    if (w_enter_nsg) begin
      walk_ew_d = pend_ew_q;
    end else if (state_d == NS_G) begin
      walk_ew_d = walk_ew_q;
    end

    walk_ns_d = 1'b0;
    if (w_enter_ewg) begin
      walk_ns_d = pend_ns_q;
    end else if (state_d == EW_G) begin
      walk_ns_d = walk_ns_q;
    end

    sec_d = sec_q;
    if (w_tmr_clr) begin
      sec_d = 8'd0;
    end else if (w_tick) begin
      sec_d = sec_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= AR_A;
      sec_q     <= 8'd0;
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      btn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_q     <= sec_d;
      pend_ns_q <= pend_ns_d;
      pend_ew_q <= pend_ew_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
      btn_q     <= btn;
    end
  end

  always_comb begin
    w_ns_rgb = COL_RED;
    w_ew_rgb = COL_RED;
    case (state_q)
      NS_G:    w_ns_rgb = COL_GRN;
      NS_Y:    w_ns_rgb = COL_YEL;
      EW_G:    w_ew_rgb = COL_GRN;
      EW_Y:    w_ew_rgb = COL_YEL;
      default: begin
        w_ns_rgb = COL_RED;
        w_ew_rgb = COL_RED;
      end
    endcase
  end

  assign ns_r    = w_ns_rgb[11:8];
  assign ns_g    = w_ns_rgb[7:4];
  assign ns_b    = w_ns_rgb[3:0];
  assign ew_r    = w_ew_rgb[11:8];
  assign ew_g    = w_ew_rgb[7:4];
  assign ew_b    = w_ew_rgb[3:0];
  assign walk_ns = walk_ns_q;
  assign walk_ew = walk_ew_q;
  assign phase   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_intersection_phase_ctrl                                           |
// | Directed vector table plus hand sequences for manual and reset cases.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_intersection_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode = 1'b0;
  logic       btn = 1'b0;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic [3:0] ns_r, ns_g, ns_b, ew_r, ew_g, ew_b;
  logic       walk_ns, walk_ew;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       m;
    logic       b;
    logic       rns;
    logic       rew;
    int         n;
    logic [2:0] ph;
    logic       wns;
    logic       wew;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  intersection_phase_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .btn       (btn),
    .ped_req_ns(ped_req_ns),
    .ped_req_ew(ped_req_ew),
    .ns_r      (ns_r),
    .ns_g      (ns_g),
    .ns_b      (ns_b),
    .ew_r      (ew_r),
    .ew_g      (ew_g),
    .ew_b      (ew_b),
    .walk_ns   (walk_ns),
    .walk_ew   (walk_ew),
    .phase     (phase)
  );

  function automatic logic [11:0] ns_col(input logic [2:0] ph);
    case (ph)
      3'd1:    return 12'h0F0;
      3'd2:    return 12'hFF0;
      default: return 12'hF00;
    endcase
  endfunction

  function automatic logic [11:0] ew_col(input logic [2:0] ph);
    case (ph)
      3'd4:    return 12'h0F0;
      3'd5:    return 12'hFF0;
      default: return 12'hF00;
    endcase
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic [2:0] ph, input logic wns, input logic wew);
    cmp("phase",   idx, {9'd0, phase}, {9'd0, ph});
    cmp("ns_rgb",  idx, {ns_r, ns_g, ns_b}, ns_col(ph));
    cmp("ew_rgb",  idx, {ew_r, ew_g, ew_b}, ew_col(ph));
    cmp("walk_ns", idx, {11'd0, walk_ns}, {11'd0, wns});
    cmp("walk_ew", idx, {11'd0, walk_ew}, {11'd0, wew});
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input logic m, input logic b, input logic rns, input logic rew,
                     input int n, input logic [2:0] ph, input logic wns, input logic wew);
    vec_t v;
    v.m = m; v.b = b; v.rns = rns; v.rew = rew;
    v.n = n; v.ph = ph; v.wns = wns; v.wew = wew;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Cumulative clock edges since reset release noted on the right.
    add(0,0,0,0,  0, 3'd0, 0,0); // 0   reset state
    add(0,0,0,0,  9, 3'd0, 0,0); // 9
    add(0,0,0,0,  1, 3'd1, 0,0); // 10
    add(0,0,0,0, 49, 3'd1, 0,0); // 59
    add(0,0,0,0,  1, 3'd2, 0,0); // 60
    add(0,0,0,0, 19, 3'd2, 0,0); // 79
    add(0,0,0,0,  1, 3'd3, 0,0); // 80
    add(0,0,0,0,  9, 3'd3, 0,0); // 89
    add(0,0,0,0,  1, 3'd4, 0,0); // 90
    add(0,0,0,0, 49, 3'd4, 0,0); // 139
    add(0,0,0,0,  1, 3'd5, 0,0); // 140
    add(0,0,0,0, 19, 3'd5, 0,0); // 159
    add(0,0,0,0,  1, 3'd0, 0,0); // 160
    add(0,0,0,1,  1, 3'd0, 0,0); // 161 ped_req_ew pulse in AR_A
    add(0,0,0,0,  8, 3'd0, 0,0); // 169
    add(0,0,0,0,  1, 3'd1, 0,1); // 170 walk_ew granted
    add(0,0,0,0, 49, 3'd1, 0,1); // 219
    add(0,0,0,0,  1, 3'd2, 0,0); // 220
    add(0,0,0,0, 20, 3'd3, 0,0); // 240
    add(0,0,0,0, 10, 3'd4, 0,0); // 250
    add(0,0,0,0, 50, 3'd5, 0,0); // 300
    add(0,0,0,0, 20, 3'd0, 0,0); // 320
    add(0,0,0,0, 10, 3'd1, 0,0); // 330 pend_ew was consumed
    add(0,0,0,0,  5, 3'd1, 0,0); // 335
    add(0,0,1,0,  1, 3'd1, 0,0); // 336 ped_req_ns 5 cycles into NS_G
    add(0,0,0,0, 13, 3'd1, 0,0); // 349
    add(0,0,0,0,  1, 3'd2, 0,0); // 350 truncated at minimum green
    add(0,0,0,0, 20, 3'd3, 0,0); // 370
    add(0,0,0,0,  9, 3'd3, 0,0); // 379
    add(0,0,0,0,  1, 3'd4, 1,0); // 380 walk_ns granted
    add(0,0,0,0, 49, 3'd4, 1,0); // 429
    add(0,0,0,0,  1, 3'd5, 0,0); // 430
    add(0,0,0,0, 20, 3'd0, 0,0); // 450
    add(0,0,0,0, 10, 3'd1, 0,0); // 460
    add(0,0,0,0, 35, 3'd1, 0,0); // 495
    add(0,0,1,0,  1, 3'd1, 0,0); // 496 ped_req_ns late in NS_G
    add(0,0,0,0,  3, 3'd1, 0,0); // 499
    add(0,0,0,0,  1, 3'd2, 0,0); // 500 exits at next tick
    add(0,0,0,0, 20, 3'd3, 0,0); // 520
    add(0,0,0,0, 10, 3'd4, 1,0); // 530
    add(0,0,0,0, 50, 3'd5, 0,0); // 580
    add(0,0,0,0, 20, 3'd0, 0,0); // 600
    add(1,0,0,0, 30, 3'd0, 0,0); // manual: AR_A held past its duration
    add(1,1,0,0,  1, 3'd1, 0,0);
    add(1,0,0,0,  1, 3'd1, 0,0);
    add(1,1,0,0,  1, 3'd2, 0,0);
    add(1,0,0,0,  1, 3'd2, 0,0);
    add(1,1,0,0,  1, 3'd3, 0,0);
    add(1,0,0,0, 20, 3'd3, 0,0); // no timed exit from AR_B
    add(1,1,0,0, 30, 3'd4, 0,0); // btn held: single advance
    add(1,0,0,0,  5, 3'd4, 0,0);
    add(0,0,0,0, 49, 3'd4, 0,0); // back to auto: full green restarts
    add(0,0,0,0,  1, 3'd5, 0,0);
    add(0,0,0,0, 20, 3'd0, 0,0);
    add(0,0,0,0, 10, 3'd1, 0,0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      mode       = vq[i].m;
      btn        = vq[i].b;
      ped_req_ns = vq[i].rns;
      ped_req_ew = vq[i].rew;
      step(vq[i].n);
      check_outs(i, vq[i].ph, vq[i].wns, vq[i].wew);
    end
    mode = 1'b0; btn = 1'b0; ped_req_ns = 1'b0; ped_req_ew = 1'b0;

    // Asynchronous reset in the middle of EW_G with pend_ns outstanding.
    step(50);             check_outs(100, 3'd2, 0, 0);
    step(20);             check_outs(101, 3'd3, 0, 0);
    ped_req_ns = 1'b1;
    step(1);
    ped_req_ns = 1'b0;
    step(9);              check_outs(102, 3'd4, 1, 0);
    step(10);
    ped_req_ns = 1'b1;
    step(1);
    ped_req_ns = 1'b0;
    step(2);              check_outs(103, 3'd4, 1, 0);
    #2 rst = 1'b1;
    #1                    check_outs(104, 3'd0, 0, 0);
    repeat (5) @(posedge clk);
    #1                    check_outs(105, 3'd0, 0, 0);
    rst = 1'b0;
    step(9);              check_outs(106, 3'd0, 0, 0);
    step(1);              check_outs(107, 3'd1, 0, 0);
    step(49);             check_outs(108, 3'd1, 0, 0);
    step(1);              check_outs(109, 3'd2, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
